// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - packs register fields and an immediate into one RV32I word, one registered stage.
// Optional IMM_RANGE_CHECK_EN flags immediates that do not fit the selected format on out_err.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       imm_sel,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      inst,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count
);

  localparam logic [2:0] SEL_I = 3'b000;
  localparam logic [2:0] SEL_S = 3'b001;
  localparam logic [2:0] SEL_B = 3'b010;
  localparam logic [2:0] SEL_U = 3'b011;
  localparam logic [2:0] SEL_J = 3'b100;

  logic             r_valid;
  logic [31:0]      r_inst;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      w_inst;
  logic             w_in_ready;
  logic             w_capture;
  logic             w_handshake;

  assign w_in_ready  = !r_valid || out_ready;
  assign w_capture   = in_valid && w_in_ready;
  assign w_handshake = r_valid && out_ready;

  always_comb begin
    w_inst = '0;
    case (imm_sel)
      SEL_I:   w_inst = {imm[11:0], rs1, funct3, rd, opcode};
      SEL_S:   w_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      SEL_B:   w_inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      SEL_U:   w_inst = {imm[31:12], rd, opcode};
      SEL_J:   w_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: w_inst = {funct7, rs2, rs1, funct3, rd, opcode};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
    end else begin
      if (w_capture) begin
        r_valid <= 1'b1;
        r_inst  <= w_inst;
      end else if (w_handshake) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Count words leaving; a same-cycle capture does not add a second increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_handshake && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic r_err;
  logic w_err;

  always_comb begin
    w_err = 1'b0;
    case (imm_sel)
      SEL_I, SEL_S: w_err = !((&imm[31:11]) || !(|imm[31:11]));
      SEL_B:        w_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      SEL_U:        w_err = |imm[11:0];
      SEL_J:        w_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      default:      w_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_capture) begin
      r_err <= w_err;
    end
  end

  assign out_err = r_err;
`else
  assign out_err = 1'b0;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_valid;
  assign inst      = r_inst;
  assign enc_count = r_count;

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - scoreboard bench for imm_encoder; honours IMM_RANGE_CHECK_EN for out_err expectations.
module tb_imm_encoder;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  imm_sel = '0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_err;
  logic [31:0] inst;
  logic [15:0] enc_count;

  logic        s_in_ready, s_out_valid, s_out_err;
  logic [31:0] s_inst;
  logic [1:0]  s_count;

  int n_cmp = 0;
  int n_fail = 0;
  logic [32:0] sb_q[$];

  imm_encoder #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm_sel(imm_sel), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .inst(inst), .out_err(out_err), .enc_count(enc_count)
  );

  imm_encoder #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .imm_sel(imm_sel), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm), .out_valid(s_out_valid),
    .out_ready(out_ready), .inst(s_inst), .out_err(s_out_err), .enc_count(s_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: got inst 0x%08h expected no word", inst);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        check("sb_inst", inst, e[31:0]);
        check("sb_err", {31'd0, out_err}, {31'd0, e[32]});
      end
    end
  end

  task automatic send(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im,
                      input logic [31:0] exp_inst, input logic exp_err, input bit want_ready);
    int budget;
    imm_sel = sel; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im; in_valid = 1'b1;
    budget = 0;
    @(negedge clk);
    if (want_ready) check("in_ready_b2b", {31'd0, in_ready}, 32'd1);
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
    sb_q.push_back({exp_err, exp_inst});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [1:0] sat_exp[5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_enc_count", {16'd0, enc_count}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    send(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0, 1'b1);
    check("i_latency_valid", {31'd0, out_valid}, 32'd1);
    check("i_inst", inst, 32'hFFF0_0093);
    @(posedge clk);
    #1;
    check("i_enc_count", {16'd0, enc_count}, 32'd1);

    send(3'b001, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423, 1'b0, 1'b1);
    send(3'b010, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 32'h0000_0863, 1'b0, 1'b1);
    send(3'b011, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0, 1'b1);
    send(3'b100, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("b2b_enc_count", {16'd0, enc_count}, 32'd5);

    send(3'b101, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4031_00B3, 1'b0, 1'b0);
    send(3'b000, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0013, RC, 1'b0);
    send(3'b010, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0000_0163, RC, 1'b0);
    send(3'b011, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000, 32'h0000_1037, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("range_enc_count", {16'd0, enc_count}, 32'd9);

    out_ready = 1'b0;
    send(3'b000, 7'h13, 5'd7, 5'd6, 5'd0, 3'd1, 7'd0, 32'h0000_0123, 32'h1233_1393, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_inst_stable", inst, 32'h1233_1393);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3'b001, 7'h23, 5'd0, 5'd3, 5'd4, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE41_8E23, 1'b0, 1'b1);
    check("bp_second_inst", inst, 32'hFE41_8E23);
    @(posedge clk);
    #1;
    check("bp_enc_count", {16'd0, enc_count}, 32'd11);
    check("sb_drained", sb_q.size(), 32'd0);

    rst_n = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send(3'b011, 7'h17, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_4000, 32'h0000_4117, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("sat_count", {30'd0, s_count}, {30'd0, sat_exp[k]});
    end

    out_ready = 1'b0;
    send(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0093, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_enc_count", {16'd0, enc_count}, 32'd0);
    check("arst_inst", inst, 32'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate sign-extension stage: packs register fields, a 32-bit immediate and a format select into one RV32I instruction word.
- Used by the self-test instruction generator and the debug "inject instruction" path ahead of instruction memory.
- One registered pipeline stage with valid/ready handshakes on both sides.
- Optional range checking, plus a saturating count of emitted words.

Parameters:
- CNT_W, 16, width of the emitted-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  stage can accept a request
- imm_sel  input  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101-111 R (no immediate)
- opcode  input  7  inst[6:0]
- rd  input  5  destination register
- rs1  input  5  source 1
- rs2  input  5  source 2
- funct3  input  3  inst[14:12]
- funct7  input  7  inst[31:25], R format only
- imm  input  32  full sign-extended immediate value
- out_valid  output  1  inst valid
- out_ready  input  1  consumer accepts
- inst  output  32  encoded instruction
- out_err  output  1  immediate not representable in the selected format
- enc_count  output  CNT_W  number of words accepted downstream, saturating

Behaviour:
- Reset (async assert, sync release): out_valid=0, inst=0, out_err=0, enc_count=0. A reset mid-transfer drops the held word.
- in_ready = !out_valid || out_ready (combinational; no skid buffer).
- Capture: when in_valid && in_ready, the encoded word loads on the next edge and out_valid=1. Latency is 1 cycle.
- Output stability: while out_valid && !out_ready, inst and out_err stay stable.
- out_valid clears on handshake unless a new request is captured in the same cycle, in which case back-to-back throughput is 1 word/cycle.
- Encoding: opcode always occupies [6:0].
  - I: imm[11:0], rs1, funct3, rd.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0].
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11].
  - U: imm[31:12], rd.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd.
  - R: funct7, rs2, rs1, funct3, rd; imm is ignored.
- Immediate bits outside the format's field are dropped silently. Flagging them is only via the optional feature.
- enc_count increments on each out_valid && out_ready. It holds at 2^CNT_W-1 once reached (no wrap).
- A simultaneous capture and output handshake increments the count once, for the word leaving.

Optional Feature:
- Macro IMM_RANGE_CHECK_EN.
- When defined, out_err is registered alongside inst and set to 1 when:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - U: imm[11:0] != 0.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - R: never.
- A word with out_err=1 is still emitted with the truncated encoding.
- When not defined, out_err is tied 0 and no check logic exists.

Test Plan:
- Reset then I-format encode: opcode=0x13, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF, out_ready=1 -> next cycle inst=0xFFF00093, out_valid=1, out_err=0, enc_count=1 one cycle later.
- Formats back-to-back, one per cycle, out_ready=1 -> inst sequence:
  - S (0x23, rs1=1, rs2=2, f3=2, imm=8) -> 0x0020A423.
  - B (0x63, imm=16) -> 0x00000863.
  - U (0x37, rd=5, imm=0x12345000) -> 0x123452B7.
  - J (0x6F, rd=1, imm=0x800) -> 0x001000EF.
  - Expected: in_ready stays 1 and enc_count=5 after the last handshake.
- Backpressure: capture a word with out_ready=0 for 3 cycles -> in_ready=0, inst stable. Assert out_ready together with a new in_valid -> first word handshakes, second is captured next edge.
- Range (macro defined): I imm=2048 -> out_err=1, inst[31:20]=0x800. B imm=3 -> out_err=1. U imm=0x1000 -> out_err=0.
- Saturation with CNT_W=2: 5 handshakes -> enc_count 1,2,3,3,3.
- Async reset asserted while out_valid=1 and out_ready=0 -> out_valid=0 and enc_count=0 immediately, without waiting for a clock edge.
